seq_divider_6bit: RTL and testbench
===================================

// Module: seq_divider_6bit
// PURPOSE
//  Multi-cycle unsigned restoring divider, the inverse (subtract) operation of the MFCC adder path.
//  Computes quotient and remainder of DATA_WIDTH-bit operands, one quotient bit per clock.
//  Uses a carry-lookahead subtractor sub-module for each trial subtraction.
//  Sits in the MFCC datapath for bin/index normalisation; driven by a start/done handshake from the controller.
// PARAMETERS
//  DATA_WIDTH   6   operand, quotient and remainder width in bits
//  CNT_WIDTH    3   iteration counter width; must hold DATA_WIDTH-1
// PORTS
//  clk          in   1             rising-edge clock
//  rst          in   1             asynchronous, active-high reset
//  start        in   1             request; accepted only when ready=1
//  dividend     in   DATA_WIDTH    numerator; sampled on accepted start
//  divisor      in   DATA_WIDTH    denominator; sampled on accepted start
//  ready        out  1             1 in IDLE only
//  done         out  1             single-cycle pulse; results valid
//  quotient     out  DATA_WIDTH    held from done until the next accepted start
//  remainder    out  DATA_WIDTH    held from done until the next accepted start
//  div_by_zero  out  1             set with done when divisor==0; held with results
// BEHAVIOUR
//  - Reset: state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
//  - Reset asserted mid-operation aborts the operation immediately. No done is produced.
//  - States:
//    - IDLE: if start, latch operands. Set Q=dividend, R=0, cnt=0, div_by_zero=0.
//      - If divisor==0, go to DONE.
//      - Otherwise go to CALC.
//    - CALC, each cycle:
//      - Form {R,Q} shifted left by 1.
//      - Compute trial = R_shifted - divisor, DATA_WIDTH+1 bits, via the sub-module.
//      - If there is no borrow (trial MSB=0): R=trial[DATA_WIDTH-1:0] and Q LSB=1.
//      - Otherwise keep R_shifted and set Q LSB=0.
//      - cnt increments. After the iteration with cnt==DATA_WIDTH-1, go to DONE.
//    - DONE: done=1 for exactly one cycle, then unconditionally return to IDLE.
//  - Latency:
//    - Start accepted at edge T gives done high in cycle T+DATA_WIDTH+1 (T+7 by default).
//    - Divide-by-zero gives done high in cycle T+1.
//  - Divide-by-zero result: quotient = all ones, remainder = dividend, div_by_zero=1.
//  - Handshake:
//    - start while ready=0 (CALC or DONE) is ignored; no queuing.
//    - start in the cycle after done is accepted normally.
//    - Back-to-back operations therefore have 1 idle cycle between done and the next accept.
//  - Width rule: the intermediate remainder is DATA_WIDTH+1 bits. Final remainder < divisor always.
//    quotient/remainder are never wider than DATA_WIDTH.
//  - Output hold: quotient and remainder registers update only on done (not visibly during CALC).
//    Internal working registers are separate.
// STRUCTURE
//  - Shared package: state encoding constants (IDLE=2'd0, CALC=2'd1, DONE=2'd2), DATA_WIDTH default.
//  - One sub-module: cla_subtractor_7bit.
//    - Operands a, b are 7 bits. Outputs diff[6:0] and borrow.
//    - Carry-lookahead form of a + ~b + 1, with p/g and an explicit carry chain.
//    - borrow = ~carry_out.
//  - Top level: FSM, counter, working Q/R registers, output registers.
// TESTING
//  - 45/7: start at T -> done at T+7, quotient=6, remainder=3, div_by_zero=0, ready=1 at T+8.
//  - 63/1 -> quotient=63, remainder=0.
//    5/9 -> quotient=0, remainder=5.
//    0/0 -> quotient=63, remainder=0, div_by_zero=1.
//  - 17/0: done at T+1 with quotient=63, remainder=17, div_by_zero=1.
//    A following 18/4 gives 4 r2 with div_by_zero=0.
//  - Start 45/7, then start 63/63 pulsed during CALC:
//    - The second request is ignored.
//    - Outputs stay 6 r3, and only one done pulse occurs.
//  - Assert rst at T+3 of 45/7 -> all outputs zero, ready=1, no done.
//    After release, 20/3 -> 6 r2.
//  - Random sweep of all 64x64 operand pairs vs a reference model.
//    Check: quotient*divisor+remainder==dividend, remainder<divisor for nonzero divisor.

Source files
------------

// File: rtl/seq_divider_6bit_pkg.sv
// rtl/seq_divider_6bit_pkg.sv - shared constants for the sequential restoring divider
package seq_divider_6bit_pkg;

    localparam int DATA_WIDTH_DEF = 6;
    localparam int CNT_WIDTH_DEF  = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cla_subtractor_7bit.sv
// rtl/cla_subtractor_7bit.sv - carry-lookahead subtractor computing a - b as a + ~b + 1
// a, b   : operands
// diff   : a - b modulo 2^WIDTH
// borrow : 1 when a < b (inverse of the adder carry out)
module cla_subtractor_7bit #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH-1:0] b_n;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH:0]   c;

    always_comb begin
        b_n  = ~b;
        p    = a ^ b_n;
        g    = a & b_n;
        c    = '0;
        // Carry-in of 1 completes the two's complement of b.
        c[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        diff   = p ^ c[WIDTH-1:0];
        borrow = ~c[WIDTH];
    end

endmodule

// File: rtl/seq_divider_6bit.sv
// rtl/seq_divider_6bit.sv - multi-cycle unsigned restoring divider, one quotient bit per clock
// clk, rst           : clock, asynchronous active-high reset
// start              : request, accepted only while ready
// dividend, divisor  : operands, sampled on an accepted start
// ready              : high in IDLE only
// done               : one-cycle pulse, results valid
// quotient, remainder: results, held until the next done
// div_by_zero        : set with done when divisor was zero
module seq_divider_6bit
    import seq_divider_6bit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  div_by_zero
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] wq_q, wq_d;
    logic [DATA_WIDTH:0]   wr_q, wr_d;
    logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
    logic [DATA_WIDTH-1:0] quot_q, quot_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic [DATA_WIDTH:0]   r_shift;
    logic [DATA_WIDTH:0]   trial;
    logic                  trial_borrow;

    // Left shift of {R,Q}: the dividend MSB moves into the partial remainder.
    assign r_shift = {wr_q[DATA_WIDTH-1:0], wq_q[DATA_WIDTH-1]};

    cla_subtractor_7bit #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_sub (
        .a      (r_shift),
        .b      ({1'b0, dvs_q}),
        .diff   (trial),
        .borrow (trial_borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wq_d    = wq_q;
        wr_d    = wr_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    wq_d  = dividend;
                    wr_d  = '0;
                    cnt_d = '0;
                    dvs_d = divisor;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                // Restore on borrow: keep the shifted remainder and shift in a 0.
                wr_d  = trial_borrow ? r_shift : trial;
                wq_d  = {wq_q[DATA_WIDTH-2:0], ~trial_borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    // Results become visible only together with done.
                    quot_d  = wq_d;
                    rem_d   = wr_d[DATA_WIDTH-1:0];
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wq_q    <= '0;
            wr_q    <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wq_q    <= wq_d;
            wr_q    <= wr_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign ready       = (state_q == ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_6bit.sv
// tb/tb_seq_divider_6bit.sv - self-checking bench for seq_divider_6bit
module tb_seq_divider_6bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [5:0] divisor;
    logic       ready;
    logic       done;
    logic [5:0] quotient;
    logic [5:0] remainder;
    logic       div_by_zero;

    int checks;
    int errors;

    seq_divider_6bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] a;
        logic [5:0] b;
        logic [5:0] q;
        logic [5:0] r;
        logic       z;
        int         lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to completion. lat is the cycle
    // (counted from the accept edge T) in which done is seen, -1 on timeout.
    task automatic run_op(input logic [5:0] a, input logic [5:0] b,
                          output int lat, output logic [5:0] q,
                          output logic [5:0] r, output logic z,
                          output logic rdy_at_start, output logic rdy_after,
                          output logic done_after);
        @(negedge clk);
        rdy_at_start = ready;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = -1;
        q = '0;
        r = '0;
        z = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (done) begin
                lat = k;
                q = quotient;
                r = remainder;
                z = div_by_zero;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rdy_after  = ready;
        done_after = done;
    endtask

    int         lat;
    logic [5:0] q, r;
    logic       z, rs, ra, da;
    int         done_cnt;
    int         sweep_bad;

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        vecs[0]  = '{6'd45, 6'd7,  6'd6,  6'd3,  1'b0, 7};
        vecs[1]  = '{6'd63, 6'd1,  6'd63, 6'd0,  1'b0, 7};
        vecs[2]  = '{6'd5,  6'd9,  6'd0,  6'd5,  1'b0, 7};
        vecs[3]  = '{6'd0,  6'd0,  6'd63, 6'd0,  1'b1, 1};
        vecs[4]  = '{6'd17, 6'd0,  6'd63, 6'd17, 1'b1, 1};
        vecs[5]  = '{6'd18, 6'd4,  6'd4,  6'd2,  1'b0, 7};
        vecs[6]  = '{6'd63, 6'd63, 6'd1,  6'd0,  1'b0, 7};
        vecs[7]  = '{6'd1,  6'd63, 6'd0,  6'd1,  1'b0, 7};
        vecs[8]  = '{6'd62, 6'd5,  6'd12, 6'd2,  1'b0, 7};
        vecs[9]  = '{6'd0,  6'd5,  6'd0,  6'd0,  1'b0, 7};
        vecs[10] = '{6'd20, 6'd3,  6'd6,  6'd2,  1'b0, 7};
        vecs[11] = '{6'd32, 6'd2,  6'd16, 6'd0,  1'b0, 7};

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", int'(ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_quotient", int'(quotient), 0);
        check("reset_remainder", int'(remainder), 0);
        check("reset_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;

        // Directed table; consecutive entries also start in the cycle right after done.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, lat, q, r, z, rs, ra, da);
            check($sformatf("vec%0d_ready_in", i), int'(rs), 1);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_quotient", i), int'(q), int'(vecs[i].q));
            check($sformatf("vec%0d_remainder", i), int'(r), int'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), int'(z), int'(vecs[i].z));
            check($sformatf("vec%0d_ready_after", i), int'(ra), 1);
            check($sformatf("vec%0d_done_pulse", i), int'(da), 0);
        end

        // Start during CALC must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 6'd45; divisor = 6'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 6'd63; divisor = 6'd63;
        @(posedge clk);
        #1;
        start = 1'b0;
        done_cnt = 0;
        q = '0; r = '0;
        for (int k = 0; k < 14; k++) begin
            if (done) begin
                done_cnt++;
                q = quotient;
                r = remainder;
            end
            @(posedge clk);
            #1;
        end
        check("ignore_done_count", done_cnt, 1);
        check("ignore_quotient", int'(q), 6);
        check("ignore_remainder", int'(r), 3);
        check("ignore_hold_quotient", int'(quotient), 6);
        check("ignore_hold_remainder", int'(remainder), 3);

        // Reset in the middle of an operation.
        run_op(6'd62, 6'd5, lat, q, r, z, rs, ra, da);
        @(negedge clk);
        start = 1'b1; dividend = 6'd45; divisor = 6'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", int'(ready), 1);
        check("midrst_done", int'(done), 0);
        check("midrst_quotient", int'(quotient), 0);
        check("midrst_remainder", int'(remainder), 0);
        check("midrst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("midrst_no_done", done_cnt, 0);
        check("midrst_ready_after", int'(ready), 1);
        run_op(6'd20, 6'd3, lat, q, r, z, rs, ra, da);
        check("postrst_latency", lat, 7);
        check("postrst_quotient", int'(q), 6);
        check("postrst_remainder", int'(r), 2);

        // Exhaustive sweep against arithmetic identities and a reference model.
        sweep_bad = 0;
        for (int a = 0; a < 64; a++) begin
            for (int b = 0; b < 64; b++) begin
                run_op(6'(a), 6'(b), lat, q, r, z, rs, ra, da);
                if (b == 0) begin
                    check($sformatf("sweep_%0d_0", a), {lat, int'(q), int'(r), int'(z)},
                          {1, 63, a, 1});
                end else begin
                    check($sformatf("sweep_%0d_%0d_lat", a, b), lat, 7);
                    check($sformatf("sweep_%0d_%0d_q", a, b), int'(q), a / b);
                    check($sformatf("sweep_%0d_%0d_r", a, b), int'(r), a % b);
                    check($sformatf("sweep_%0d_%0d_identity", a, b),
                          int'(q) * b + int'(r), a);
                    check($sformatf("sweep_%0d_%0d_rlt", a, b), int'(int'(r) < b), 1);
                    check($sformatf("sweep_%0d_%0d_dbz", a, b), int'(z), 0);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
